// File: rtl/viterbi_pkg.sv
// viterbi_pkg: constants and the survivor-memory state encoding shared by
// the ACS array, the survivor memory and the traceback unit.
//   M      : state bits, N = 2^M states per trellis row
//   D      : survivor buffer depth (equals the traceback depth)
//   PTR_W  : row pointer width
//   FILL_W : fill counter width (counts 0..D inclusive)
package viterbi_pkg;

  localparam int M      = 6;
  localparam int N      = 1 << M;
  localparam int D      = 40;
  localparam int PTR_W  = $clog2(D);
  localparam int FILL_W = $clog2(D + 1);

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_RUN     = 2'd1,
    ST_TB_WAIT = 2'd2
  } sm_state_e;

endpackage

// File: rtl/survivor_mem_surv_ram.sv
// surv_ram: ROWS x COLS survivor bit array.
//   clk, rst         : clock, synchronous active-high reset (read register only)
//   we, wr_row       : full-row write strobe and row index
//   wr_data          : row of COLS survivor bits
//   rd_row, rd_col   : single-bit read address
//   rd_bit           : registered read data, one cycle after the address
// A row index >= ROWS reads as 0. A read and write of the same row in one
// cycle returns the previous contents.
module surv_ram
  import viterbi_pkg::*;
#(
  parameter int ROWS = D,
  parameter int COLS = N
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [$clog2(ROWS)-1:0]    wr_row,
  input  logic [COLS-1:0]            wr_data,
  input  logic [$clog2(ROWS)-1:0]    rd_row,
  input  logic [$clog2(COLS)-1:0]    rd_col,
  output logic                       rd_bit
);

  localparam int RW = $clog2(ROWS);

  logic [COLS-1:0] mem_q [ROWS];
  logic            rd_bit_d;
  logic            rd_bit_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[wr_row] <= wr_data;
  end

  always_comb begin
    rd_bit_d = 1'b0;
    if (rd_row < RW'(ROWS)) rd_bit_d = mem_q[rd_row][rd_col];
  end

  always_ff @(posedge clk) begin
    if (rst) rd_bit_q <= 1'b0;
    else     rd_bit_q <= rd_bit_d;
  end

  assign rd_bit = rd_bit_q;

endmodule

// File: rtl/survivor_mem.sv
// survivor_mem: circular survivor-decision buffer between the ACS array and
// the traceback unit.
//   clk, rst      : clock, synchronous active-high reset
//   dec_valid/dec_ready, dec_bits, s_best, term_zero : ACS row handshake
//   wr_ptr        : row index of the most recent write
//   s_end         : end state for the pending traceback
//   force_state0  : one-cycle traceback launch pulse
//   tb_time, tb_state, tb_surv_bit : traceback single-bit read port
//   tb_done       : traceback finished (level, may be held several cycles)
//   full          : buffer holds D rows
module survivor_mem
  import viterbi_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [N-1:0]     dec_bits,
  input  logic [M-1:0]     s_best,
  input  logic             term_zero,
  output logic             dec_ready,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [M-1:0]     s_end,
  output logic             force_state0,
  input  logic [PTR_W-1:0] tb_time,
  input  logic [M-1:0]     tb_state,
  output logic             tb_surv_bit,
  input  logic             tb_done,
  output logic             full
);

  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(D - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(D);

  sm_state_e         state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [M-1:0]      s_end_q, s_end_d;
  logic              force_q, force_d;
  logic              tb_done_q;
  logic              wr_en;
  logic              tb_done_rise;
  logic [PTR_W-1:0]  wr_row;

  assign wr_row = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    s_end_d      = s_end_q;
    force_d      = 1'b0;
    // Rows are refused while a traceback may still be reading them.
    dec_ready    = !rst && (state_q != ST_TB_WAIT);
    wr_en        = dec_valid && dec_ready;
    tb_done_rise = tb_done && !tb_done_q;

    if (wr_en) begin
      wr_ptr_d = wr_row;
      s_end_d  = term_zero ? '0 : s_best;
      fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
      // Launch once the write completes a full window of D rows.
      if (state_q == ST_RUN || fill_q >= FILL_MAX - 1'b1) begin
        force_d = 1'b1;
        state_d = ST_TB_WAIT;
      end
    end

    // Only the rising edge counts, so a held tb_done cannot release a
    // later traceback early.
    if (state_q == ST_TB_WAIT && tb_done_rise) state_d = ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FILL;
      wr_ptr_q  <= PTR_LAST;
      fill_q    <= '0;
      s_end_q   <= '0;
      force_q   <= 1'b0;
      tb_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      fill_q    <= fill_d;
      s_end_q   <= s_end_d;
      force_q   <= force_d;
      tb_done_q <= tb_done;
    end
  end

  assign wr_ptr       = wr_ptr_q;
  assign s_end        = s_end_q;
  assign force_state0 = force_q;
  assign full         = (fill_q == FILL_MAX);

  surv_ram #(
    .ROWS(D),
    .COLS(N)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we     (wr_en),
    .wr_row (wr_row),
    .wr_data(dec_bits),
    .rd_row (tb_time),
    .rd_col (tb_state),
    .rd_bit (tb_surv_bit)
  );

endmodule
